jtag_tap_ctrl: RTL
==================

// Module: jtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1-style TAP controller sequencing the device's data registers from TCK/TMS/TDI.
//  Holds a 16-state TAP FSM and an instruction register (IR).
//  Decodes IDCODE/BYPASS(/USER) and generates shift strobes for the 8-bit device ID register.
//  Muxes the selected register's serial output onto TDO. Sits between the chip JTAG pins and the DR blocks.
// PARAMETERS
//  IR_W        4        instruction register width
//  OP_IDCODE   4'b0001  selects device ID DR; IR reset value
//  OP_BYPASS   4'b1111  selects 1-bit bypass DR; any undecoded opcode also selects bypass
//  OP_USER     4'b0010  selects external user DR (only with JTAG_USER_DR_EN)
// PORTS
//  TCK        in   1     test clock; FSM/IR/bypass on posedge, TDO/IR update on negedge
//  D_RST      in   1     reset, asynchronous, active-low
//  TMS        in   1     mode select, sampled posedge TCK
//  TDI        in   1     serial data in, sampled posedge TCK
//  TDO        out  1     serial data out, changes on negedge TCK
//  TDO_EN     out  1     high while in SHIFT_IR/SHIFT_DR (registered negedge)
//  ID_SHIFT   out  1     shift clock strobe to device ID reg: ~TCK & id_sel & state==SHIFT_DR
//  ID_ENABLE  out  1     id_sel & state==SHIFT_DR
//  ID_RST     out  1     active-low reset to ID reg: low when D_RST low or in TEST_LOGIC_RESET/CAPTURE_DR
//  ID_TDO     in   1     serial output of device ID reg
//  IR_OUT     out  IR_W  current (updated) instruction
//  TAP_STATE  out  4     current FSM state encoding
// BEHAVIOUR
//  Reset: D_RST low -> state TEST_LOGIC_RESET, IR=OP_IDCODE, ir_shreg=0, bypass=0, TDO=0, TDO_EN=0.
//  FSM states (4-bit enc in pkg): TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
//    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR. Transitions are the standard 1149.1 TMS graph.
//    Examples: TLR -TMS0-> RTI; SEL_IR -TMS1-> TLR; UPD_x -TMS0-> RTI, -TMS1-> SEL_DR.
//  Five TCK with TMS=1 reach TLR from any state. Entering TLR loads IR=OP_IDCODE on the same posedge.
//  CAP_IR: ir_shreg <= {0..0,2'b01}. SH_IR: ir_shreg <= {TDI, ir_shreg[IR_W-1:1]} (LSB out first).
//  UPD_IR: IR_OUT <= ir_shreg on negedge TCK. IR is otherwise stable, including through DR scans.
//  CAP_DR: bypass <= 0. SH_DR: bypass <= TDI.
//  ID reg is reset via ID_RST in CAP_DR, so each IDCODE scan restarts at bit 0.
//  TDO mux (negedge TCK): SH_IR -> ir_shreg[0]; SH_DR & id_sel -> ID_TDO;
//    SH_DR & bypass_sel -> bypass; else hold 0.
//  TDO_EN follows with the same negedge timing.
//  ID_SHIFT is gated only while ~TCK; the state changes on posedge, so the strobe is glitch-free.
//  Its first rising edge is the negedge after entering SH_DR.
//  Pause states (PA_x) hold all shift registers. Exit→Shift via EX2 resumes with no bit loss.
//  Decode: id_sel = IR==OP_IDCODE; bypass_sel = otherwise (user_sel removes OP_USER when enabled).
//  Reset mid-scan: async return to TLR; partially shifted ir_shreg discarded; IR_OUT=OP_IDCODE.
// CONFIGURATION
//  JTAG_USER_DR_EN defined: adds ports USER_SHIFT/USER_CAPTURE/USER_UPDATE (out, 1) and USER_TDO (in, 1).
//    On OP_USER: SHIFT/CAPTURE/UPDATE are decoded from SH_DR/CAP_DR/UPD_DR, and TDO muxes USER_TDO.
//  Not defined: ports absent, OP_USER decodes as bypass.
// STRUCTURE
//  Package jtag_pkg: TAP state enum/localparams (16 x 4-bit), opcode constants, IR_W default.
//  Sub-module jtag_tap_fsm: state register + next-state logic only (TCK, D_RST, TMS -> state).
//    The top holds IR, bypass, decode and TDO mux.
// TESTING
//  1. Reset D_RST low mid-SH_IR -> TAP_STATE=TLR, IR_OUT=4'b0001, TDO=0, TDO_EN=0.
//  2. From RTI, TMS 1,1,0,0, then four SH_IR clocks with TDI 1,1,1,1 and TMS=1 on the last
//     -> TDO bits out 1,0,0,0 (capture 0001), then UPD_IR gives IR_OUT=4'b1111.
//  3. IDCODE: DR scan of 8 bits -> TDO sequence 1,1,0,1,0,1,0,1 (8'hAB LSB first).
//     A second scan repeats the same sequence.
//  4. BYPASS: shift TDI pattern 1,0,1,1 -> TDO shows 0,1,0,1 (one-cycle delay, leading capture 0).
//  5. Any state, five TCK with TMS=1 -> TLR, IR_OUT=OP_IDCODE.
//     Sweep all 16 states x TMS 0/1 against the reference graph.
//  6. Pause: IDCODE scan of 3 bits, PA_DR for 4 TCK, resume -> remaining bits 1,0,1,0,1 with no skip.
//     With JTAG_USER_DR_EN, OP_USER routes USER_TDO to TDO.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: the TAP state encoding,
// the default instruction width and the instruction opcodes.
package jtag_pkg;

  localparam int DEF_IR_W = 4;

  localparam logic [3:0] DEF_OP_IDCODE = 4'b0001;
  localparam logic [3:0] DEF_OP_BYPASS = 4'b1111;
  localparam logic [3:0] DEF_OP_USER   = 4'b0010;

  // Classic 1149.1 encoding, so that the state value on a logic analyser
  // matches what most JTAG tools print.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  // True in either of the two states that move data through TDI/TDO.
  function automatic logic is_shift_state(input tap_state_e s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// The 16-state TAP state machine. It only tracks the state from TMS;
// the registers that react to the state live in jtag_tap_ctrl.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       D_RST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register: async return to Test-Logic-Reset, otherwise advance on TCK.
  always_ff @(posedge TCK or negedge D_RST) begin
    if (!D_RST) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the TMS graph; TMS=1 five times always lands in TLR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PA_DR;
      PA_DR:   state_d = TMS ? EX2_DR : PA_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PA_IR;
      PA_IR:   state_d = TMS ? EX2_IR : PA_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // The state is published as-is; consumers decode what they need.
  always_comb begin
    state = state_q;
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: instruction register, bypass register, instruction
// decode, device-ID shift strobes and the TDO output mux.
// Optional feature macro: JTAG_USER_DR_EN adds a user data register
// interface selected by the OP_USER instruction.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int              IR_W      = DEF_IR_W,
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(DEF_OP_IDCODE),
  parameter logic [IR_W-1:0] OP_BYPASS = IR_W'(DEF_OP_BYPASS),
  parameter logic [IR_W-1:0] OP_USER   = IR_W'(DEF_OP_USER)
) (
  input  logic            TCK,
  input  logic            D_RST,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_EN,
  output logic            ID_SHIFT,
  output logic            ID_ENABLE,
  output logic            ID_RST,
  input  logic            ID_TDO,
`ifdef JTAG_USER_DR_EN
  output logic            USER_SHIFT,
  output logic            USER_CAPTURE,
  output logic            USER_UPDATE,
  input  logic            USER_TDO,
`endif
  output logic [IR_W-1:0] IR_OUT,
  output logic [3:0]      TAP_STATE
);

  tap_state_e      state;
  logic [IR_W-1:0] ir_reg;
  logic [IR_W-1:0] ir_shreg;
  logic            bypass_reg;
  logic            in_sh_dr;
  logic            in_sh_ir;
  logic            id_sel;
  logic            bypass_sel;
  logic            tdo_next;

  jtag_tap_fsm u_fsm (
    .TCK   (TCK),
    .D_RST (D_RST),
    .TMS   (TMS),
    .state (state)
  );

  assign TAP_STATE = state;
  assign in_sh_dr  = (state == SH_DR);
  assign in_sh_ir  = (state == SH_IR);

  // In TLR the instruction is IDCODE from the very edge that entered it,
  // even though ir_reg itself only reloads on the following falling edge.
  assign IR_OUT = (state == TLR) ? OP_IDCODE : ir_reg;

  assign id_sel = (IR_OUT == OP_IDCODE);

`ifdef JTAG_USER_DR_EN
  logic user_sel;
  assign user_sel     = (IR_OUT == OP_USER);
  assign bypass_sel   = ~id_sel & ~user_sel;
  assign USER_SHIFT   = user_sel & in_sh_dr;
  assign USER_CAPTURE = user_sel & (state == CAP_DR);
  assign USER_UPDATE  = user_sel & (state == UPD_DR);
`else
  logic unused_user_op;
  assign unused_user_op = ^OP_USER;
  assign bypass_sel     = ~id_sel;
`endif

  // OP_BYPASS is the explicit bypass opcode; every undecoded value also
  // lands on bypass, so it needs no comparator of its own.
  logic unused_bypass_op;
  assign unused_bypass_op = ^OP_BYPASS;

  // The strobe is only open during the low phase of TCK and the state only
  // moves on the rising edge, so ID_SHIFT cannot glitch.
  assign ID_SHIFT  = ~TCK & id_sel & in_sh_dr;
  assign ID_ENABLE = id_sel & in_sh_dr;
  assign ID_RST    = D_RST & ~((state == TLR) | (state == CAP_DR));

  // IR shift register: capture the fixed 01 pattern, then shift LSB-first.
  always_ff @(posedge TCK or negedge D_RST) begin
    if (!D_RST) begin
      ir_shreg <= '0;
    end else if (state == CAP_IR) begin
      ir_shreg <= IR_W'(2'b01);
    end else if (in_sh_ir) begin
      ir_shreg <= {TDI, ir_shreg[IR_W-1:1]};
    end
  end

  // Bypass register: cleared on capture, one-bit delay line while shifting.
  always_ff @(posedge TCK or negedge D_RST) begin
    if (!D_RST) begin
      bypass_reg <= 1'b0;
    end else if (state == CAP_DR) begin
      bypass_reg <= 1'b0;
    end else if (in_sh_dr) begin
      bypass_reg <= TDI;
    end
  end

  // Active instruction: loaded on the falling edge in UPD_IR, forced to IDCODE in TLR.
  always_ff @(negedge TCK or negedge D_RST) begin
    if (!D_RST) begin
      ir_reg <= OP_IDCODE;
    end else if (state == TLR) begin
      ir_reg <= OP_IDCODE;
    end else if (state == UPD_IR) begin
      ir_reg <= ir_shreg;
    end
  end

  // Pick the serial source for the register currently being shifted.
  always_comb begin
    tdo_next = 1'b0;
    if (in_sh_ir) begin
      tdo_next = ir_shreg[0];
    end else if (in_sh_dr) begin
      if (id_sel) begin
        tdo_next = ID_TDO;
`ifdef JTAG_USER_DR_EN
      end else if (user_sel) begin
        tdo_next = USER_TDO;
`endif
      end else if (bypass_sel) begin
        tdo_next = bypass_reg;
      end
    end
  end

  // TDO and its enable change on the falling edge so the far end samples a stable bit.
  always_ff @(negedge TCK or negedge D_RST) begin
    if (!D_RST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= tdo_next;
      TDO_EN <= is_shift_state(state);
    end
  end

endmodule
